wide_decimal_parser: RTL

WIDE_DECIMAL_PARSER -- requirements
Module: wide_decimal_parser

---
 rtl/wide_decimal_parser.sv | 97 +++++++++
 1 files changed

// File: rtl/wide_decimal_parser.sv
// Streaming ASCII decimal parser: accumulates digits into a WIDTH-bit value,
// skipping leading spaces and '_' separators, and holds the result until taken.
module wide_decimal_parser #(
    parameter int WIDTH = 1024,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_empty,
    output logic [CNTW-1:0]  out_ndigits
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             take;
    logic             is_digit;
    logic [3:0]       digit;
    logic [WIDTH+3:0] acc_x10;

    assign in_ready  = (state_q != DONE);
    assign take      = in_valid && in_ready;
    assign is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign digit     = in_char[3:0];

    // Four guard bits are enough: 10*(2^WIDTH-1)+9 < 2^(WIDTH+4).
    assign acc_x10   = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                     + {{WIDTH{1'b0}}, digit};

    assign out_valid   = (state_q == DONE);
    assign out_data    = acc_q;
    assign out_ovf     = ovf_q;
    assign out_ndigits = cnt_q;
    assign out_empty   = (state_q == DONE) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (take) begin
                    if (is_digit) begin
                        acc_d   = acc_x10[WIDTH-1:0];
                        ovf_d   = ovf_q | (|acc_x10[WIDTH+3:WIDTH]);
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
                        end
                        state_d = ACCUM;
                    end else if ((state_q == IDLE) && (in_char == 8'h20)) begin
                        state_d = IDLE;
                    end else if ((state_q == ACCUM) && (in_char == 8'h5F)) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
